bootrom_loader: RTL and testbench

- Bus initiator that drives the boot ROM read interface (read_op/bus_addr/bus_data_read).
- Copies a fixed-size block of words from boot ROM into RAM through a write-request/ready port.
- Sits between the bootrom controller and the RAM controller.
- Holds the CPU off (busy) until the copy completes, then flags done.

---
 rtl/bootrom_loader.sv | 109 ++++++++++
 tb/tb_bootrom_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_loader.sv
// Boot ROM to RAM block copier: reads WORDS words from the ROM port and writes them to RAM.
// Optional BOOTROM_LOADER_CHECKSUM_EN builds a running 32-bit sum of accepted writes.
module bootrom_loader #(
  parameter logic [31:0] SRC_BASE    = 32'h0000_0000,
  parameter logic [31:0] DST_BASE    = 32'h8000_0000,
  parameter int          WORDS       = 1024,
  parameter int          ROM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rom_read_op,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        ram_write_op,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  input  logic        ram_ready,
  output logic [15:0] word_idx,
  output logic [31:0] checksum
);
  typedef enum logic [2:0] {IDLE, ROM_REQ, ROM_WAIT, RAM_WRITE, DONE} state_e;

  localparam int            CW   = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);
  localparam logic [CW-1:0] LAT  = CW'(ROM_LATENCY);
  localparam logic [15:0]   LAST = 16'(WORDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   idx_q;
  logic [31:0]   data_q;
  logic [31:0]   rom_addr_q;
  logic          start_ok, accept;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign accept   = (state_q == RAM_WRITE) && ram_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ROM_REQ;
      ROM_REQ:    state_d = ROM_WAIT;
      ROM_WAIT:   if (cnt_q == CW'(1)) state_d = RAM_WRITE;
      RAM_WRITE:  if (ram_ready) state_d = (idx_q == LAST) ? DONE : ROM_REQ;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == ROM_REQ) || (state_q == ROM_WAIT) || (state_q == RAM_WRITE);
    done         = (state_q == DONE);
    rom_read_op  = (state_q == ROM_REQ);
    rom_addr     = rom_addr_q;
    ram_write_op = (state_q == RAM_WRITE);
    ram_addr     = '0;
    ram_data     = '0;
    if (state_q == RAM_WRITE) begin
      ram_addr = DST_BASE + {14'b0, idx_q, 2'b00};
      ram_data = data_q;
    end
    word_idx = idx_q;
  end

  // rom_addr_q tracks SRC_BASE + 4*idx so it is already valid in the ROM_REQ cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rom_addr_q <= '0;
    end else if (start_ok) begin
      idx_q      <= '0;
      rom_addr_q <= SRC_BASE;
    end else begin
      case (state_q)
        ROM_REQ:  cnt_q <= LAT;
        ROM_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) data_q <= rom_data;
        end
        RAM_WRITE: if (accept && idx_q != LAST) begin
          idx_q      <= idx_q + 16'd1;
          rom_addr_q <= rom_addr_q + 32'd4;
        end
        default: ;
      endcase
    end
  end

`ifdef BOOTROM_LOADER_CHECKSUM_EN
  logic [31:0] cs_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cs_q <= '0;
    else if (start_ok) cs_q <= '0;
    else if (accept)   cs_q <= cs_q + data_q;
  end
  assign checksum = cs_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_bootrom_loader.sv
// Scoreboard bench for bootrom_loader: a 4-word/latency-2 instance and a 1-word/latency-1 instance.
module tb_bootrom_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ram_ready, mode;
  logic        busy, done, rom_read_op, ram_write_op;
  logic [31:0] rom_addr, rom_data, ram_addr, ram_data, checksum;
  logic [15:0] word_idx;

  logic        start1, ram_ready1;
  logic        busy1, done1, rom_read_op1, ram_write_op1;
  logic [31:0] rom_addr1, rom_data1, ram_addr1, ram_data1, checksum1;
  logic [15:0] word_idx1;

  bootrom_loader #(.WORDS(4), .ROM_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_read_op(rom_read_op), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_write_op(ram_write_op), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ready(ram_ready), .word_idx(word_idx), .checksum(checksum));

  bootrom_loader #(.WORDS(1), .ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rom_read_op(rom_read_op1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .ram_write_op(ram_write_op1), .ram_addr(ram_addr1), .ram_data(ram_data1),
    .ram_ready(ram_ready1), .word_idx(word_idx1), .checksum(checksum1));

  function automatic logic [31:0] romf(input logic [31:0] a);
    if (!mode) return a ^ 32'hA5A5_0000;
    case (a[3:2])
      2'd0:    return 32'h1;
      2'd1:    return 32'h2;
      2'd2:    return 32'h3;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // ROM models: data only valid exactly ROM_LATENCY cycles after the read_op cycle
  logic        rd1 = 0, rd2 = 0, r1rd = 0;
  logic [31:0] a1 = 0, a2 = 0, r1a = 0;
  always @(posedge clk) begin
    rd1 <= rom_read_op;  a1 <= rom_addr;
    rd2 <= rd1;          a2 <= a1;
    r1rd <= rom_read_op1; r1a <= rom_addr1;
  end
  assign rom_data  = rd2  ? romf(a2)  : 32'hDEAD_BEEF;
  assign rom_data1 = r1rd ? romf(r1a) : 32'hDEAD_BEEF;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t q[$], q1[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, rd_cnt = 0, rd_cnt1 = 0, done_cyc = -1, done1_cyc = -1;
  logic done_prev = 0, done1_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write, tracks read order and done rise time
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (rom_read_op) begin chk("rom_addr", rom_addr, 32'(4 * rd_cnt)); rd_cnt++; end
      if (rom_read_op1) begin chk("rom_addr1", rom_addr1, 32'(4 * rd_cnt1)); rd_cnt1++; end
      if (ram_write_op && ram_ready) begin
        if (q.size() == 0) chk("extra_write", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_data, e.d);
        end
      end
      if (ram_write_op1 && ram_ready1) begin
        if (q1.size() == 0) chk("extra_write1", 32'(q1.size()), 32'd1);
        else begin
          e = q1.pop_front();
          chk("wr_addr1", ram_addr1, e.a);
          chk("wr_data1", ram_data1, e.d);
        end
      end
      if (done && !done_prev) done_cyc = cyc;
      if (done1 && !done1_prev) done1_cyc = cyc;
    end
    done_prev  = done;
    done1_prev = done1;
  end

  task automatic push_run();
    for (int i = 0; i < 4; i++)
      q.push_back('{a: 32'h8000_0000 + 32'(4 * i), d: romf(32'(4 * i))});
  endtask

  task automatic do_start(output int s);
    rd_cnt = 0; done_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int s, input int lat, input string nm);
    for (int k = 0; k < 200 && !done; k++) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk(nm, 32'(done_cyc - s), 32'(lat));
    chk({nm, "_reads"}, 32'(rd_cnt), 32'd4);
    chk({nm, "_sb_empty"}, 32'(q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flags"}, {28'b0, busy, done, rom_read_op, ram_write_op}, 32'd0);
    chk({nm, "_rom_addr"}, rom_addr, 32'd0);
    chk({nm, "_ram_addr"}, ram_addr, 32'd0);
    chk({nm, "_ram_data"}, ram_data, 32'd0);
    chk({nm, "_idx_cs"}, {16'b0, word_idx} | checksum, 32'd0);
  endtask

  initial begin
    int s;
    rst = 1'b0; start = 1'b0; ram_ready = 1'b1; mode = 1'b0;
    start1 = 1'b0; ram_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset1_flags", {28'b0, busy1, done1, rom_read_op1, ram_write_op1}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic 4-word copy
    push_run();
    do_start(s);
    wait_done(s, 16, "lat_basic");

    // single word, latency 1
    q1.push_back('{a: 32'h8000_0000, d: 32'hA5A5_0000});
    rd_cnt1 = 0; done1_cyc = -1;
    start1 = 1'b1;
    @(posedge clk); #1;
    s = cyc; start1 = 1'b0;
    for (int k = 0; k < 50 && !done1; k++) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk("lat_single", 32'(done1_cyc - s), 32'd3);
    chk("single_reads", 32'(rd_cnt1), 32'd1);
    chk("single_sb_empty", 32'(q1.size()), 32'd0);

    // ram_ready stall on word 1
    @(posedge clk); #1;
    push_run();
    do_start(s);
    for (int k = 0; k < 50 && !(rom_read_op && word_idx == 16'd1); k++) begin @(posedge clk); #1; end
    chk("reach_w1", {30'b0, rom_read_op, word_idx == 16'd1}, 32'd3);
    ram_ready = 1'b0;
    for (int k = 0; k < 50 && !ram_write_op; k++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_ops", {30'b0, ram_write_op, rom_read_op}, 32'd2);
      chk("stall_addr", ram_addr, 32'h8000_0004);
      chk("stall_data", ram_data, 32'hA5A5_0004);
      @(posedge clk); #1;
    end
    ram_ready = 1'b1;
    wait_done(s, 21, "lat_stall");

    // start while busy is ignored
    @(posedge clk); #1;
    push_run();
    do_start(s);
    for (int k = 0; k < 50 && word_idx != 16'd2; k++) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(s, 16, "lat_ignore");
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", {30'b0, done, busy}, 32'd2);

    // restart from DONE, checksum data set
    mode = 1'b1;
    push_run();
    do_start(s);
    chk("restart_flags", {30'b0, done, busy}, 32'd1);
    chk("restart_idx", {16'b0, word_idx}, 32'd0);
    wait_done(s, 16, "lat_restart");
`ifdef BOOTROM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, 32'h0000_0005);
`else
    chk("checksum", checksum, 32'h0000_0000);
`endif

    // reset during ROM_WAIT of word 2
    mode = 1'b0;
    push_run();
    do_start(s);
    for (int k = 0; k < 50 && !(rom_read_op && word_idx == 16'd2); k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", {30'b0, done, busy}, 32'd0);
    push_run();
    do_start(s);
    wait_done(s, 16, "lat_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
